// File: rtl/voice_mix_scheduler.sv
// Polyphonic playback sequencer. Each audio frame it walks the voice slots,
// fetches one stereo sample per active voice over a req/ack memory port,
// mixes the samples in wide accumulators and writes the saturated 24-bit
// frame to the codec data FIFO with a one-cycle strobe.
module voice_mix_scheduler #(
    parameter int NUM_VOICES = 8,
    parameter int ADDR_W     = 32,
    parameter int SAMPLE_W   = 24
) (
    input  logic                          axi_clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          fifo_full,
    output logic [2*SAMPLE_W-1:0]         data_in,
    output logic                          data_wr,
    input  logic                          cfg_wr,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic                          cfg_stop,
    input  logic [ADDR_W-1:0]             cfg_start_addr,
    input  logic [ADDR_W-1:0]             cfg_end_addr,
    output logic                          mem_rd_req,
    output logic [ADDR_W-1:0]             mem_rd_addr,
    input  logic                          mem_rd_ack,
    input  logic [2*SAMPLE_W-1:0]         mem_rd_data,
    output logic [NUM_VOICES-1:0]         voice_active,
    output logic [NUM_VOICES-1:0]         voice_done,
    output logic                          busy
);

    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + VW;
    localparam int DW    = 2 * SAMPLE_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_FETCH  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [VW-1:0]            v_q;
    logic [NUM_VOICES-1:0]    active_q;
    logic [NUM_VOICES-1:0]    done_q;
    logic [ADDR_W-1:0]        addr_q [NUM_VOICES];
    logic [ADDR_W-1:0]        end_q  [NUM_VOICES];
    logic signed [ACC_W-1:0]  acc_l_q;
    logic signed [ACC_W-1:0]  acc_r_q;

    logic                     last_voice;
    logic                     frame_go;
    logic                     frame_begin;
    logic                     ack_take;
    logic                     advance;
    logic                     cfg_hit;
    logic [ADDR_W-1:0]        cur_addr;
    logic [ADDR_W-1:0]        cur_end;
    logic                     at_end;

    // Sign-extend one channel sample to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
        return {{VW{s[SAMPLE_W-1]}}, s};
    endfunction

    // Clamp an accumulator to the signed SAMPLE_W range.
    function automatic logic [SAMPLE_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = {{(VW + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
        lo = {{(VW + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};
        if (a > hi) begin
            return hi[SAMPLE_W-1:0];
        end else if (a < lo) begin
            return lo[SAMPLE_W-1:0];
        end else begin
            return a[SAMPLE_W-1:0];
        end
    endfunction

    // Shared decode of the current voice slot and frame-start conditions.
    always_comb begin
        last_voice  = (v_q == VW'(NUM_VOICES - 1));
        frame_go    = enable && !fifo_full;
        // The IDLE start decision is also taken in OUTPUT so back-to-back
        // frames run at NUM_VOICES+1 cycles without an idle bubble.
        frame_begin = frame_go && ((state_q == S_IDLE) || (state_q == S_OUTPUT));
        ack_take    = (state_q == S_FETCH) && mem_rd_ack;
        advance     = ((state_q == S_SCAN) && !active_q[v_q]) || ack_take;
        cfg_hit     = cfg_wr && (cfg_voice == v_q);
        cur_addr    = addr_q[v_q];
        cur_end     = end_q[v_q];
        at_end      = (cur_addr >= cur_end);
    end

    // FSM state register.
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_go) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (active_q[v_q]) begin
                    state_d = S_FETCH;
                end else if (last_voice) begin
                    state_d = S_OUTPUT;
                end
            end
            S_FETCH: begin
                if (mem_rd_ack) begin
                    state_d = last_voice ? S_OUTPUT : S_SCAN;
                end
            end
            S_OUTPUT: begin
                state_d = frame_go ? S_SCAN : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: memory request, FIFO write and status.
    always_comb begin
        mem_rd_req  = 1'b0;
        mem_rd_addr = '0;
        data_wr     = 1'b0;
        data_in     = '0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_FETCH: begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = cur_addr;
            end
            S_OUTPUT: begin
                data_wr = 1'b1;
                data_in = {sat(acc_l_q), sat(acc_r_q)};
            end
            default: begin
                mem_rd_req = 1'b0;
            end
        endcase
    end

    // Voice index and mix accumulators.
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            v_q     <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
        end else if (frame_begin) begin
            v_q     <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
        end else begin
            if (ack_take) begin
                acc_l_q <= acc_l_q + sext(mem_rd_data[DW-1:SAMPLE_W]);
                acc_r_q <= acc_r_q + sext(mem_rd_data[SAMPLE_W-1:0]);
            end
            if (advance && !last_voice) begin
                v_q <= v_q + VW'(1);
            end
        end
    end

    // Voice table: playback pointer advance, end detection and config writes.
    // A config write to the voice being acked overrides the pointer update
    // and suppresses its done pulse; the sample itself is still mixed.
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            active_q <= '0;
            done_q   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                addr_q[i] <= '0;
                end_q[i]  <= '0;
            end
        end else begin
            done_q <= '0;
            if (ack_take && !cfg_hit) begin
                if (at_end) begin
                    active_q[v_q] <= 1'b0;
                    done_q[v_q]   <= 1'b1;
                end else begin
                    addr_q[v_q] <= cur_addr + ADDR_W'(1);
                end
            end
            if (cfg_wr) begin
                if (cfg_stop) begin
                    active_q[cfg_voice] <= 1'b0;
                end else begin
                    addr_q[cfg_voice]   <= cfg_start_addr;
                    end_q[cfg_voice]    <= cfg_end_addr;
                    active_q[cfg_voice] <= 1'b1;
                end
            end
        end
    end

    assign voice_active = active_q;
    assign voice_done   = done_q;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Testbench for voice_mix_scheduler: directed scenarios, a sample memory
// responder with programmable ack delay, and a frame scoreboard.
module tb_voice_mix_scheduler;

    localparam int NV = 8;
    localparam int AW = 32;
    localparam int SW = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              fifo_full;
    logic [2*SW-1:0]   data_in;
    logic              data_wr;
    logic              cfg_wr;
    logic [2:0]        cfg_voice;
    logic              cfg_stop;
    logic [AW-1:0]     cfg_start_addr;
    logic [AW-1:0]     cfg_end_addr;
    logic              mem_rd_req;
    logic [AW-1:0]     mem_rd_addr;
    logic              mem_rd_ack;
    logic [2*SW-1:0]   mem_rd_data;
    logic [NV-1:0]     voice_active;
    logic [NV-1:0]     voice_done;
    logic              busy;

    always #5 clk = ~clk;

    voice_mix_scheduler #(.NUM_VOICES(NV), .ADDR_W(AW), .SAMPLE_W(SW)) dut (
        .axi_clk(clk), .reset(reset), .enable(enable), .fifo_full(fifo_full),
        .data_in(data_in), .data_wr(data_wr), .cfg_wr(cfg_wr), .cfg_voice(cfg_voice),
        .cfg_stop(cfg_stop), .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .voice_active(voice_active), .voice_done(voice_done),
        .busy(busy)
    );

    int            n_total = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            frames_seen = 0;
    int            done_cnt [NV];
    bit            req_seen = 1'b0;
    int            ack_delay = 0;
    int            last_req_len = 0;
    bit            stop_on_ack = 1'b0;
    logic [AW-1:0] stop_addr = '0;
    bit            cfg_from_resp = 1'b0;
    logic [2*SW-1:0] exp_q [$];
    int            stamp_q [$];
    logic [AW-1:0] addr_log [$];
    logic [2*SW-1:0] mem [logic [AW-1:0]];
    logic [2*SW-1:0] mon_e;
    logic [AW-1:0] req_addr0;
    int            req_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tout(input string nm);
        n_total++;
        n_fail++;
        $display("FAIL %s: timed out waiting, got no event, expected one", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_seen < target && n < 400) begin
            step();
            n++;
        end
        if (frames_seen < target) tout("frame_wait");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            step();
            n++;
        end
        if (busy !== 1'b0) tout("idle_wait");
    endtask

    task automatic one_frame(input logic [2*SW-1:0] e);
        int target;
        wait_idle();
        target = frames_seen + 1;
        exp_q.push_back(e);
        enable = 1'b1;
        step();
        enable = 1'b0;
        wait_frames(target);
    endtask

    task automatic cfg(input int v, input bit stp, input logic [AW-1:0] s, input logic [AW-1:0] e);
        cfg_wr = 1'b1;
        cfg_voice = 3'(v);
        cfg_stop = stp;
        cfg_start_addr = s;
        cfg_end_addr = e;
        step();
        cfg_wr = 1'b0;
        cfg_stop = 1'b0;
    endtask

    // Frame scoreboard and output monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (data_wr === 1'b1) begin
                frames_seen++;
                stamp_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got data_in=0x%0h, expected no write", data_in);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frame_data", 64'(data_in), 64'(mon_e));
                end
            end
            for (int i = 0; i < NV; i++) begin
                if (voice_done[i] === 1'b1) done_cnt[i]++;
            end
            if (mem_rd_req === 1'b1) begin
                req_seen = 1'b1;
                chk("busy_with_req", 64'(busy), 64'd1);
            end
        end
    end

    // Sample memory responder.
    initial begin
        mem_rd_ack = 1'b0;
        mem_rd_data = '0;
        req_cnt = 0;
        forever begin
            @(negedge clk);
            if (cfg_from_resp) begin
                cfg_wr = 1'b0;
                cfg_stop = 1'b0;
                cfg_from_resp = 1'b0;
            end
            if (mem_rd_req === 1'b1) begin
                if (req_cnt == 0) req_addr0 = mem_rd_addr;
                else chk("addr_stable", 64'(mem_rd_addr), 64'(req_addr0));
                req_cnt++;
                if (req_cnt > ack_delay) begin
                    mem_rd_ack = 1'b1;
                    mem_rd_data = mem.exists(mem_rd_addr) ? mem[mem_rd_addr] : '0;
                    addr_log.push_back(mem_rd_addr);
                    last_req_len = req_cnt;
                    if (stop_on_ack && mem_rd_addr == stop_addr) begin
                        cfg_wr = 1'b1;
                        cfg_voice = 3'd0;
                        cfg_stop = 1'b1;
                        cfg_from_resp = 1'b1;
                        stop_on_ack = 1'b0;
                    end
                end else begin
                    mem_rd_ack = 1'b0;
                end
            end else begin
                mem_rd_ack = 1'b0;
                req_cnt = 0;
            end
        end
    end

    // Directed scenarios.
    initial begin
        int base;
        int d0;
        int n;
        reset = 1'b1;
        enable = 1'b0;
        fifo_full = 1'b0;
        cfg_wr = 1'b0;
        cfg_voice = '0;
        cfg_stop = 1'b0;
        cfg_start_addr = '0;
        cfg_end_addr = '0;
        for (int i = 0; i < NV; i++) done_cnt[i] = 0;
        repeat (3) step();

        // Reset state.
        chk("rst_data_wr", 64'(data_wr), 64'd0);
        chk("rst_data_in", 64'(data_in), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req", 64'(mem_rd_req), 64'd0);
        chk("rst_active", 64'(voice_active), 64'd0);
        chk("rst_done", 64'(voice_done), 64'd0);
        reset = 1'b0;
        step();

        // Silence: free-running frames with no voices.
        base = frames_seen;
        req_seen = 1'b0;
        repeat (3) exp_q.push_back('0);
        enable = 1'b1;
        wait_frames(base + 2);
        enable = 1'b0;
        wait_frames(base + 3);
        repeat (3) step();
        chk("silence_count", 64'(frames_seen), 64'(base + 3));
        chk("silence_idle", 64'(busy), 64'd0);
        chk("silence_no_req", 64'(req_seen), 64'd0);
        chk("period_1", 64'(stamp_q[base + 1] - stamp_q[base]), 64'd9);
        chk("period_2", 64'(stamp_q[base + 2] - stamp_q[base + 1]), 64'd9);

        // Voice 2 plays three samples then finishes.
        mem[32'h100] = 48'h000010_000010;
        mem[32'h101] = 48'h000010_000010;
        mem[32'h102] = 48'h000010_000010;
        addr_log.delete();
        d0 = done_cnt[2];
        cfg(2, 1'b0, 32'h100, 32'h102);
        chk("v2_active", 64'(voice_active[2]), 64'd1);
        repeat (3) one_frame(48'h000010_000010);
        chk("v2_fetch_count", 64'(addr_log.size()), 64'd3);
        chk("v2_addr0", 64'(addr_log[0]), 64'h100);
        chk("v2_addr1", 64'(addr_log[1]), 64'h101);
        chk("v2_addr2", 64'(addr_log[2]), 64'h102);
        chk("v2_inactive", 64'(voice_active[2]), 64'd0);
        chk("v2_done_once", 64'(done_cnt[2] - d0), 64'd1);
        one_frame('0);
        chk("v2_no_more_fetch", 64'(addr_log.size()), 64'd3);

        // Saturation with all eight voices at full scale.
        for (int i = 0; i < NV; i++) begin
            mem[32'h200 + 32'(i)] = 48'h7FFFFF_800000;
            cfg(i, 1'b0, 32'h200 + 32'(i), 32'h200 + 32'(i));
        end
        chk("all_active", 64'(voice_active), 64'hFF);
        one_frame(48'h7FFFFF_800000);
        chk("all_done_inactive", 64'(voice_active), 64'd0);

        // Mixed signs: +0x100000 + -0x080000 on L; 0 + 1 on R.
        mem[32'h300] = 48'h100000_000000;
        mem[32'h301] = 48'hF80000_000001;
        cfg(0, 1'b0, 32'h300, 32'h300);
        cfg(1, 1'b0, 32'h301, 32'h301);
        one_frame(48'h080000_000001);

        // Slow memory: ack after five wait cycles.
        ack_delay = 5;
        mem[32'h400] = 48'h000123_FFFFFF;
        cfg(3, 1'b0, 32'h400, 32'h400);
        one_frame(48'h000123_FFFFFF);
        chk("slow_req_len", 64'(last_req_len), 64'd6);
        ack_delay = 0;

        // fifo_full blocks frame start in IDLE, but not a running frame.
        base = frames_seen;
        fifo_full = 1'b1;
        enable = 1'b1;
        repeat (5) step();
        chk("full_busy", 64'(busy), 64'd0);
        chk("full_no_frame", 64'(frames_seen), 64'(base));
        exp_q.push_back('0);
        fifo_full = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (busy !== 1'b1) tout("full_start");
        fifo_full = 1'b1;
        enable = 1'b0;
        wait_frames(base + 1);
        repeat (12) step();
        chk("full_one_frame", 64'(frames_seen), 64'(base + 1));
        chk("full_idle", 64'(busy), 64'd0);
        fifo_full = 1'b0;

        // Stop voice 0 in the very cycle its sample is acked.
        mem[32'h500] = 48'h000005_000006;
        d0 = done_cnt[0];
        stop_addr = 32'h500;
        stop_on_ack = 1'b1;
        cfg(0, 1'b0, 32'h500, 32'h500);
        one_frame(48'h000005_000006);
        repeat (2) step();
        chk("stop_fired", 64'(stop_on_ack), 64'd0);
        chk("stop_inactive", 64'(voice_active[0]), 64'd0);
        chk("stop_no_done", 64'(done_cnt[0] - d0), 64'd0);

        // Reset in the middle of a fetch aborts the frame.
        base = frames_seen;
        ack_delay = 20;
        cfg(1, 1'b0, 32'h600, 32'h6FF);
        wait_idle();
        enable = 1'b1;
        step();
        enable = 1'b0;
        n = 0;
        while (mem_rd_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (mem_rd_req !== 1'b1) tout("abort_req");
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("abort_req_drop", 64'(mem_rd_req), 64'd0);
        chk("abort_data_wr", 64'(data_wr), 64'd0);
        chk("abort_data_in", 64'(data_in), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_active", 64'(voice_active), 64'd0);
        chk("abort_done", 64'(voice_done), 64'd0);
        step();
        reset = 1'b0;
        ack_delay = 0;
        repeat (20) step();
        chk("abort_no_frame", 64'(frames_seen), 64'(base));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
